lt24_touch_spi_slave: RTL and testbench
=======================================

Name: lt24_touch_spi_slave

Overview:
SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) with a memory-mapped CPU register interface. It is the responder end of the touch SPI master link. It is used to emulate the LT24 touch controller in loopback and board-bring-up builds, and as a generic SPI peripheral port. External SCLK, SS_n and MOSI are asynchronous and are oversampled in the clk domain.

Parameters:
DATABITS, 8, frame width in bits (shift, holding and rx registers).
SYNC_STAGES, 2, synchronizer flops on SCLK/SS_n/MOSI (min 2).
TX_FILL, 8'h00, byte shifted out on transmit underrun.

Ports:
clk  in  1  system clock; must be >= 8x SCLK frequency
reset  in  1  asynchronous, active-high reset
SCLK  in  1  SPI clock from master
SS_n  in  1  slave select, active low
MOSI  in  1  serial data from master
MISO  out  1  serial data to master; 0 when not selected
MISO_oe  out  1  tristate enable for MISO pad; 1 only while selected
spi_select  in  1  register-port chip select
mem_addr  in  3  register address
read_n  in  1  read strobe, active low
write_n  in  1  write strobe, active low
data_from_cpu  in  16  write data
data_to_cpu  out  16  read data, registered
irq  out  1  registered interrupt
dataavailable  out  1  equals RRDY
readyfordata  out  1  equals TRDY

Behaviour:
- Reset values: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0, all status and enable bits 0 except TRDY=1. Synchronizers reset to idle (SCLK=0, SS_n=1, MOSI=0). armed=0.
- Register map:
  - 0: rxdata (r).
  - 1: txdata (w).
  - 2: status (r; any write clears ROE/TUE/TOE/ABT/RRDY).
  - 3: control (r/w): [0] iRRDY, [1] iTRDY, [2] iE.
  - 4-7: read 0, writes ignored.
- Status bits: [0] RRDY, [1] TRDY, [2] ROE, [3] TUE, [4] TOE, [5] ABT, [6] SEL (synced SS_n low), [7] E = ROE|TUE|TOE|ABT. Bits [15:8] read as 0.
- CPU access:
  - Access cycle = spi_select & ~read_n (or ~write_n).
  - data_to_cpu is loaded from mem_addr on every clk, so read data is valid one cycle after the address.
  - A read of addr 0 clears RRDY in its access cycle. A multi-cycle read clears it each cycle, which is harmless.
  - txdata write while TRDY=1: tx_hold <= data_from_cpu[7:0], TRDY <= 0.
  - txdata write while TRDY=0: data discarded, TOE <= 1.
- Edge detection:
  - Rising, falling and SS edges are detected on the last two synchronizer stages.
  - Every SPI-side event therefore lags the pin by SYNC_STAGES to SYNC_STAGES+1 clk.
- Arming:
  - armed is set when synced SS_n is seen high.
  - An SS_n falling edge is honoured only if armed=1. A frame already in progress at reset release is ignored entirely: MISO_oe stays 0 and RRDY is not set.
- States:
  - IDLE: MISO_oe=0.
  - SS fall (armed) -> SHIFT. Load shift_out from tx_hold if TRDY=0, then TRDY <= 1; else load TX_FILL and set TUE. Set bitcnt=0 and MISO_oe=1. MISO = shift_out[7] within SYNC_STAGES+1 clk of the SS_n fall.
  - SHIFT, SCLK rise: shift_in <= {shift_in[6:0], MOSI_sync}, bitcnt++.
  - SHIFT, SCLK fall with bitcnt != 0 and != DATABITS: shift_out <<= 1.
  - bitcnt reaches DATABITS (8th rise): rx <= completed shift_in, RRDY <= 1, ROE <= 1 if RRDY was already 1 (the old rx is overwritten). Then reload shift_out for the next frame from tx_hold or TX_FILL (with TUE set), using the same rule as on SS fall. bitcnt <= 0. The new MSB is presented on the following SCLK fall.
  - SS rise in SHIFT -> IDLE, MISO_oe <= 0. If bitcnt != 0: partial data discarded, ABT <= 1, RRDY unchanged.
- Simultaneous events:
  - A set event (RRDY/ROE/TUE/ABT/TOE) wins over a status-write clear in the same cycle.
  - An RRDY set wins over an rxdata-read clear in the same cycle.
  - A txdata write in the same cycle as a shift_out load: the load takes the pre-write tx_hold/TRDY state; the written byte stays primed for the next frame.
- irq (registered, 1 clk latency) = (RRDY&iRRDY) | (TRDY&iTRDY) | (E&iE).
- Reset asserted mid-frame: immediate return to reset values. Resumption requires SS_n high, then low.

Test Plan:
- Reset, then status read -> 0x0002, MISO_oe=0, irq=0.
- Write txdata 0xA5; master sends 0x3C with SCLK = clk/16 -> MISO bits 1,0,1,0,0,1,0,1; rxdata reads 0x3C; RRDY=1 then 0 after the read; TRDY=1 again.
- Two back-to-back frames under one SS_n, no txdata write, rx not read -> TUE=1 and ROE=1; E=1; with iE=1, irq=1 one clk after the flag; status write -> 0x0042 (SEL and TRDY still set) while SS_n is low.
- SS_n deasserted after 3 SCLK rises -> ABT=1, RRDY=0, MISO_oe=0 within 3 clk.
- Two txdata writes without a frame in between -> second write discarded, TOE=1, next frame shifts the first byte.
- Reset released while SS_n is low mid-frame -> no RRDY and MISO_oe=0 for that frame; the next full frame after SS_n goes high then low is received correctly.

Source files
------------

// File: rtl/lt24_touch_spi_slave.sv
// ---------------------------------------------------------------------------
// lt24_touch_spi_slave
//
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) with a small CPU register
// port. It answers the touch SPI master. It serves as an LT24 touch controller
// stand-in and as a generic SPI peripheral. SCLK, SS_n and MOSI are
// asynchronous. They are oversampled in the clk domain, so clk must run at
// least 8x SCLK.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   SCLK, SS_n, MOSI    SPI inputs from the master (asynchronous)
//   MISO, MISO_oe       serial data to the master and its pad enable
//   spi_select          register-port chip select
//   mem_addr            register address (0 rx, 1 tx, 2 status, 3 control)
//   read_n, write_n     active-low access strobes
//   data_from_cpu       write data
//   data_to_cpu         registered read data (valid one clk after the address)
//   irq                 registered interrupt
//   dataavailable       RRDY
//   readyfordata        TRDY
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lt24_touch_spi_slave #(
  parameter int unsigned         DATABITS    = 8,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [DATABITS-1:0] TX_FILL     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int unsigned CW = $clog2(DATABITS + 1);
  localparam int unsigned FW = $clog2(SYNC_STAGES);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t          CNT_LAST  = cnt_t'(DATABITS - 1);
  localparam cnt_t          CNT_FULL  = cnt_t'(DATABITS);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizers. Stage 0 takes the pin. Edges are taken between the
  // last two stages.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic [FW-1:0]          fill_cnt;

  // NOTE: the synchronizers reset to the idle bus state (SCLK low, SS_n high).
  // Any activity already on the pins at reset release is therefore seen as a
  // fresh edge. The armed flag keeps such an edge from starting a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      fill_cnt  <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // stage samples the value its predecessor held before this edge.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      if (fill_cnt != FILL_DONE) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  logic sclk_now, sclk_old, ss_now, ss_old, mosi_now, sync_valid;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_now   = sclk_sync[SYNC_STAGES-2];
  assign sclk_old   = sclk_sync[SYNC_STAGES-1];
  assign ss_now     = ss_sync[SYNC_STAGES-2];
  assign ss_old     = ss_sync[SYNC_STAGES-1];
  // MOSI is set half an SCLK period before the rise. The oldest stage is
  // stable well before the rise is detected.
  assign mosi_now   = mosi_sync[SYNC_STAGES-1];
  // Stage SYNC_STAGES-2 holds a real pin sample, not a reset value.
  assign sync_valid = (fill_cnt == FILL_DONE);

  assign sclk_rise  =  sclk_now & ~sclk_old;
  assign sclk_fall  = ~sclk_now &  sclk_old;
  assign ss_fall    = ~ss_now   &  ss_old;
  assign ss_rise    =  ss_now   & ~ss_old;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t              state, next_state;
  logic                armed;
  cnt_t                bitcnt;
  logic [DATABITS-1:0] shift_in, shift_out, rx_data, tx_hold;
  logic                rrdy, trdy, roe, tue, toe, abt;
  logic [2:0]          ctrl;

  // CPU access decode
  logic rd_access, wr_access;
  logic rx_rd, tx_wr, status_wr, ctrl_wr;

  assign rd_access = spi_select & ~read_n;
  assign wr_access = spi_select & ~write_n;
  assign rx_rd     = rd_access & (mem_addr == 3'd0);
  assign tx_wr     = wr_access & (mem_addr == 3'd1);
  assign status_wr = wr_access & (mem_addr == 3'd2);
  assign ctrl_wr   = wr_access & (mem_addr == 3'd3);

  // -------------------------------------------------------------------------
  // Frame FSM: next state plus one-cycle datapath strobes
  // -------------------------------------------------------------------------
  logic load_tx, shift_in_en, capture, shift_out_en, abort;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    next_state   = state;
    load_tx      = 1'b0;
    shift_in_en  = 1'b0;
    capture      = 1'b0;
    shift_out_en = 1'b0;
    abort        = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_fall && armed) begin
          next_state = S_SHIFT;
          load_tx    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (ss_rise) begin
          next_state = S_IDLE;
          abort      = (bitcnt != '0) && (bitcnt != CNT_FULL);
        end else if (sclk_rise && (bitcnt != CNT_FULL)) begin
          shift_in_en = 1'b1;
          capture     = (bitcnt == CNT_LAST);
        end else if (sclk_fall) begin
          // After the last rise the next frame's byte is loaded on the
          // following fall. Its MSB appears exactly when the master expects
          // the next bit.
          if (bitcnt == CNT_FULL) load_tx = 1'b1;
          else if (bitcnt != '0)  shift_out_en = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // -------------------------------------------------------------------------
  // Datapath and status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      bitcnt    <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rx_data   <= '0;
      tx_hold   <= '0;
      rrdy      <= 1'b0;
      trdy      <= 1'b1;
      roe       <= 1'b0;
      tue       <= 1'b0;
      toe       <= 1'b0;
      abt       <= 1'b0;
      ctrl      <= '0;
    end else begin
      // A frame in progress at reset release must not be joined. A start
      // is honoured only after SS_n has been seen high.
      if (sync_valid && ss_now) armed <= 1'b1;

      if (load_tx)          bitcnt <= '0;
      else if (shift_in_en) bitcnt <= bitcnt + 1'b1;

      if (shift_in_en) shift_in <= {shift_in[DATABITS-2:0], mosi_now};

      // The load sees the TRDY/tx_hold values from before this edge. A CPU
      // write in the same cycle stays primed for the following frame.
      if (load_tx)           shift_out <= trdy ? TX_FILL : tx_hold;
      else if (shift_out_en) shift_out <= {shift_out[DATABITS-2:0], 1'b0};

      if (capture) rx_data <= {shift_in[DATABITS-2:0], mosi_now};

      if (tx_wr && trdy) tx_hold <= data_from_cpu[DATABITS-1:0];

      if (tx_wr && trdy)         trdy <= 1'b0;
      else if (load_tx && !trdy) trdy <= 1'b1;

      // Set events take priority over CPU clears in the same cycle.
      if (capture)                 rrdy <= 1'b1;
      else if (status_wr || rx_rd) rrdy <= 1'b0;

      if (capture && rrdy) roe <= 1'b1;
      else if (status_wr)  roe <= 1'b0;

      if (load_tx && trdy) tue <= 1'b1;
      else if (status_wr)  tue <= 1'b0;

      if (tx_wr && !trdy)  toe <= 1'b1;
      else if (status_wr)  toe <= 1'b0;

      if (abort)           abt <= 1'b1;
      else if (status_wr)  abt <= 1'b0;

      if (ctrl_wr) ctrl <= data_from_cpu[2:0];
    end
  end

  // -------------------------------------------------------------------------
  // Register read port and interrupt
  // -------------------------------------------------------------------------
  logic        err;
  logic [15:0] status, rd_mux;

  assign err    = roe | tue | toe | abt;
  assign status = 16'({err, ~ss_now, abt, toe, tue, roe, trdy, rrdy});

  always_comb begin
    rd_mux = '0;
    case (mem_addr)
      3'd0:    rd_mux = 16'(rx_data);
      3'd2:    rd_mux = status;
      3'd3:    rd_mux = 16'(ctrl);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      data_to_cpu <= rd_mux;
      irq         <= (rrdy & ctrl[0]) | (trdy & ctrl[1]) | (err & ctrl[2]);
    end
  end

  assign MISO_oe       = (state == S_SHIFT);
  assign MISO          = MISO_oe & shift_out[DATABITS-1];
  assign dataavailable = rrdy;
  assign readyfordata  = trdy;

  // Upper write-data bits have no register behind them.
  logic unused_cpu_bits;
  assign unused_cpu_bits = ^data_from_cpu[15:DATABITS];

endmodule

// File: tb/tb_lt24_touch_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_lt24_touch_spi_slave
//
// Directed and randomized bench for lt24_touch_spi_slave. A frame-level
// reference model tracks the pending transmit byte, the received byte and the
// sticky flags. An SPI master task drives SCLK at clk/16.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lt24_touch_spi_slave;

  localparam int         HALF = 8;      // clk cycles per SCLK half period
  localparam logic [7:0] FILL = 8'hE7;  // underrun byte used by this bench

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK, SS_n, MOSI;
  logic        MISO, MISO_oe;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n, write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lt24_touch_spi_slave #(.TX_FILL(FILL)) dut (
    .clk           (clk),
    .reset         (reset),
    .SCLK          (SCLK),
    .SS_n          (SS_n),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .MISO_oe       (MISO_oe),
    .spi_select    (spi_select),
    .mem_addr      (mem_addr),
    .read_n        (read_n),
    .write_n       (write_n),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu),
    .irq           (irq),
    .dataavailable (dataavailable),
    .readyfordata  (readyfordata)
  );

  // ---------------------------------------------------------------- model --
  logic       m_tx_valid;  // a byte is waiting to be sent (TRDY = 0)
  logic [7:0] m_tx_byte, m_rx, m_out;
  logic       m_rrdy, m_roe, m_tue, m_toe, m_abt;
  logic [2:0] m_ctrl;

  task automatic m_reset();
    m_tx_valid = 1'b0; m_tx_byte = '0; m_rx = '0; m_out = '0;
    m_rrdy = 1'b0; m_roe = 1'b0; m_tue = 1'b0; m_toe = 1'b0; m_abt = 1'b0;
    m_ctrl = '0;
  endtask

  // The byte the slave commits to send for the next frame.
  task automatic m_load();
    if (m_tx_valid) begin
      m_out = m_tx_byte;
      m_tx_valid = 1'b0;
    end else begin
      m_out = FILL;
      m_tue = 1'b1;
    end
  endtask

  task automatic m_receive(input logic [7:0] b);
    if (m_rrdy) m_roe = 1'b1;
    m_rx   = b;
    m_rrdy = 1'b1;
  endtask

  function automatic logic [15:0] m_status(input logic sel);
    logic e;
    e = m_roe | m_tue | m_toe | m_abt;
    return {8'h00, e, sel, m_abt, m_toe, m_tue, m_roe, ~m_tx_valid, m_rrdy};
  endfunction

  function automatic logic m_irq();
    logic e;
    e = m_roe | m_tue | m_toe | m_abt;
    return (m_rrdy & m_ctrl[0]) | (~m_tx_valid & m_ctrl[1]) | (e & m_ctrl[2]);
  endfunction

  // ------------------------------------------------------------- checking --
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ CPU side --
  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
    case (a)
      3'd1: if (!m_tx_valid) begin m_tx_valid = 1'b1; m_tx_byte = d[7:0]; end
            else m_toe = 1'b1;
      3'd2: begin m_rrdy = 1'b0; m_roe = 1'b0; m_tue = 1'b0; m_toe = 1'b0; m_abt = 1'b0; end
      3'd3: m_ctrl = d[2:0];
      default: ;
    endcase
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(negedge clk);
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
    if (a == 3'd0) m_rrdy = 1'b0;
  endtask

  // ------------------------------------------------------------- SPI side --
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = MISO;          // master samples just before its rising edge
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    m_load();
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic full_frame(input logic [7:0] mo, input string tag);
    logic [7:0] got;
    logic [7:0] exp_out;
    exp_out = m_out;
    spi_xfer(mo, 8, got);
    check(tag, 16'(got), 16'(exp_out));
    m_receive(mo);
    m_load();                  // the slave reloads after every full frame
  endtask

  // ------------------------------------------------------------- watchdog --
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------- stimulus --
  initial begin
    logic [15:0] d;
    logic [7:0]  got;
    logic        seen, prev_irq;

    reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    spi_select = 1'b0; mem_addr = '0; read_n = 1'b1; write_n = 1'b1;
    data_from_cpu = '0;
    m_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso_oe", 16'(MISO_oe), 16'h0);
    check("rst_miso",    16'(MISO),    16'h0);
    check("rst_irq",     16'(irq),     16'h0);
    check("rst_dout",    data_to_cpu,  16'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    cpu_read(3'd2, d);
    check("rst_status", d, 16'h0002);
    check("rst_trdy", 16'(readyfordata),  16'h1);
    check("rst_rrdy", 16'(dataavailable), 16'h0);

    // Unmapped addresses
    cpu_write(3'd5, 16'hFFFF);
    cpu_read(3'd5, d);
    check("unmapped_rd", d, 16'h0000);
    cpu_read(3'd3, d);
    check("ctrl_untouched", d, 16'(m_ctrl));

    // Basic frame: send 0xA5, receive 0x3C
    cpu_write(3'd1, 16'h00A5);
    check("trdy_cleared", 16'(readyfordata), 16'h0);
    ss_low();
    repeat (4) @(negedge clk);
    check("oe_selected", 16'(MISO_oe), 16'h1);
    full_frame(8'h3C, "miso_a5");
    ss_high();
    check("oe_released", 16'(MISO_oe), 16'h0);
    check("rrdy_set", 16'(dataavailable), 16'h1);
    cpu_read(3'd2, d);
    check("status_after_a5", d, m_status(1'b0));
    cpu_read(3'd0, d);
    check("rx_3c", d, 16'h003C);
    check("rrdy_cleared", 16'(dataavailable), 16'h0);
    check("trdy_again", 16'(readyfordata), 16'h1);

    // Randomized frames
    for (int k = 0; k < 6; k++) begin
      int nwr;
      cpu_write(3'd3, 16'($urandom_range(0, 7)));
      nwr = $urandom_range(0, 2);
      for (int w = 0; w < nwr; w++) cpu_write(3'd1, 16'($urandom));
      ss_low();
      full_frame(8'($urandom), "rnd_miso");
      ss_high();
      cpu_read(3'd2, d);
      check("rnd_status", d, m_status(1'b0));
      check("rnd_irq", 16'(irq), 16'(m_irq()));
      if ($urandom_range(0, 1) == 1) begin
        cpu_read(3'd0, d);
        check("rnd_rx", d, 16'(m_rx));
      end
      if ($urandom_range(0, 2) == 0) cpu_write(3'd2, 16'h0000);
    end

    // Back-to-back frames under one SS_n: underrun, overrun, irq timing
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd0, d);
    cpu_write(3'd3, 16'h0004);
    @(negedge clk);
    mem_addr = 3'd2;
    repeat (2) @(negedge clk);
    check("b2b_irq_idle", 16'(irq), 16'(m_irq()));
    prev_irq = irq;
    seen = 1'b0;
    ss_low();
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (!seen && data_to_cpu[7]) begin
        seen = 1'b1;
        check("irq_with_e",  16'(irq),      16'h1);
        check("irq_before_e", 16'(prev_irq), 16'h0);
      end
      prev_irq = irq;
    end
    check("e_flag_seen", 16'(seen), 16'h1);
    full_frame(8'h11, "b2b_miso0");
    full_frame(8'h22, "b2b_miso1");
    repeat (4) @(negedge clk);
    cpu_read(3'd2, d);
    check("b2b_status", d, m_status(1'b1));
    check("b2b_irq", 16'(irq), 16'(m_irq()));
    cpu_read(3'd0, d);
    check("b2b_rx", d, 16'h0022);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, d);
    check("b2b_cleared", d, m_status(1'b1));
    check("b2b_cleared_0042", d, 16'h0042);
    ss_high();
    cpu_write(3'd3, 16'h0000);

    // Abort after three bits
    cpu_write(3'd2, 16'h0000);
    ss_low();
    spi_xfer(8'($urandom), 3, got);
    check("abt_miso_bits", 16'(got[7:5]), 16'(m_out[7:5]));
    SS_n  = 1'b1;
    m_abt = 1'b1;
    repeat (3) @(negedge clk);
    check("abt_oe", 16'(MISO_oe), 16'h0);
    repeat (2) @(negedge clk);
    cpu_read(3'd2, d);
    check("abt_status", d, m_status(1'b0));
    check("abt_rrdy", 16'(dataavailable), 16'h0);

    // Transmit overrun: second write discarded
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd1, 16'h005A);
    cpu_write(3'd1, 16'h00C3);
    check("toe_trdy", 16'(readyfordata), 16'h0);
    cpu_read(3'd2, d);
    check("toe_status", d, m_status(1'b0));
    ss_low();
    full_frame(8'($urandom), "toe_miso_5a");
    ss_high();
    cpu_read(3'd2, d);
    check("toe_status_after", d, m_status(1'b0));
    cpu_read(3'd0, d);
    check("toe_rx", d, 16'(m_rx));

    // Reset released in the middle of a frame
    cpu_write(3'd1, 16'h0033);
    SS_n = 1'b0;
    spi_xfer(8'hF0, 3, got);
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spi_xfer(8'h0F, 5, got);
    check("rstmid_miso", 16'(got), 16'h0000);
    check("rstmid_oe", 16'(MISO_oe), 16'h0);
    ss_high();
    cpu_read(3'd2, d);
    check("rstmid_status", d, 16'h0002);
    check("rstmid_rrdy", 16'(dataavailable), 16'h0);
    cpu_write(3'd1, 16'h0096);
    ss_low();
    full_frame(8'h69, "rstmid_next_miso");
    ss_high();
    cpu_read(3'd0, d);
    check("rstmid_next_rx", d, 16'h0069);
    cpu_read(3'd2, d);
    check("rstmid_next_status", d, m_status(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
